// File: rtl/reply_latency_meter.sv
// Measures the cycles between the end of a guess frame and the MCU's YES/NO reply byte,
// reports each measurement, and tracks the longest latency and the first YES guess.
module reply_latency_meter #(
   parameter int unsigned CNT_W   = 24,
   parameter int unsigned TIMEOUT = 5_000_000
) (
   input  logic             CLK_50,
   input  logic             SW,
   input  logic             guess_sent,
   input  logic [7:0]       guess_byte,
   input  logic [7:0]       bus_byte,
   input  logic             clear_stats,
   output logic             result_valid,
   output logic [7:0]       result_guess,
   output logic [CNT_W-1:0] result_cycles,
   output logic [1:0]       result_kind,
   output logic [CNT_W-1:0] max_cycles,
   output logic [7:0]       max_guess,
   output logic             found,
   output logic [7:0]       found_guess
);

   typedef enum logic [1:0] {StIdle, StMeasure, StReport} state_e;

   localparam logic [7:0]       YesByte    = 8'h03;
   localparam logic [7:0]       NoByte     = 8'h04;
   localparam logic [1:0]       KindNo     = 2'b00;
   localparam logic [1:0]       KindYes    = 2'b01;
   localparam logic [1:0]       KindTmo    = 2'b10;
   localparam logic [CNT_W-1:0] CntLast    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;
   logic [7:0]       guess_q, guess_d;
   logic [7:0]       result_guess_q, result_guess_d;
   logic [CNT_W-1:0] result_cycles_q, result_cycles_d;
   logic [1:0]       result_kind_q, result_kind_d;
   logic [CNT_W-1:0] max_cycles_q, max_cycles_d;
   logic [7:0]       max_guess_q, max_guess_d;
   logic             found_q, found_d;
   logic [7:0]       found_guess_q, found_guess_d;

   logic is_reply;
   logic reply_hit;
   logic at_last;

   assign is_reply  = (bus_byte == YesByte) || (bus_byte == NoByte);
   // A reply only counts once the bus has shown a non-reply value since the guess went out.
   assign reply_hit = armed_q && is_reply;
   assign at_last   = (cnt_q == CntLast);

   // State and datapath registers with synchronous reset
   always_ff @(posedge CLK_50) begin
      if (SW) begin
         state_q         <= StIdle;
         cnt_q           <= '0;
         armed_q         <= 1'b0;
         guess_q         <= '0;
         result_guess_q  <= '0;
         result_cycles_q <= '0;
         result_kind_q   <= '0;
         max_cycles_q    <= '0;
         max_guess_q     <= '0;
         found_q         <= 1'b0;
         found_guess_q   <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         armed_q         <= armed_d;
         guess_q         <= guess_d;
         result_guess_q  <= result_guess_d;
         result_cycles_q <= result_cycles_d;
         result_kind_q   <= result_kind_d;
         max_cycles_q    <= max_cycles_d;
         max_guess_q     <= max_guess_d;
         found_q         <= found_d;
         found_guess_q   <= found_guess_d;
      end
   end

   // Next-state logic; a new guess restarts measurement from any state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (guess_sent) state_d = StMeasure;
         end
         StMeasure: begin
            if (guess_sent)                state_d = StMeasure;
            else if (reply_hit || at_last) state_d = StReport;
            else                           state_d = StMeasure;
         end
         StReport: begin
            state_d = guess_sent ? StMeasure : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Measurement datapath: capture guess, count, arm, and latch the result
   always_comb begin
      cnt_d           = cnt_q;
      armed_d         = armed_q;
      guess_d         = guess_q;
      result_guess_d  = result_guess_q;
      result_cycles_d = result_cycles_q;
      result_kind_d   = result_kind_q;
      if (guess_sent) begin
         guess_d = guess_byte;
         cnt_d   = '0;
         armed_d = !is_reply;
      end else if (state_q == StMeasure) begin
         if (!armed_q && !is_reply) armed_d = 1'b1;
         if (reply_hit) begin
            result_guess_d  = guess_q;
            result_cycles_d = cnt_q;
            result_kind_d   = (bus_byte == YesByte) ? KindYes : KindNo;
         end else if (at_last) begin
            result_guess_d  = guess_q;
            result_cycles_d = TimeoutVal;
            result_kind_d   = KindTmo;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Statistics update on the report cycle; clear_stats has priority
   always_comb begin
      max_cycles_d  = max_cycles_q;
      max_guess_d   = max_guess_q;
      found_d       = found_q;
      found_guess_d = found_guess_q;
      if (state_q == StReport && result_kind_q != KindTmo) begin
         // Strict compare so ties keep the earlier guess.
         if (result_cycles_q > max_cycles_q) begin
            max_cycles_d = result_cycles_q;
            max_guess_d  = result_guess_q;
         end
         if (result_kind_q == KindYes && !found_q) begin
            found_d       = 1'b1;
            found_guess_d = result_guess_q;
         end
      end
      if (clear_stats) begin
         max_cycles_d  = '0;
         max_guess_d   = '0;
         found_d       = 1'b0;
         found_guess_d = '0;
      end
   end

   // Outputs
   always_comb begin
      result_valid  = (state_q == StReport);
      result_guess  = result_guess_q;
      result_cycles = result_cycles_q;
      result_kind   = result_kind_q;
      max_cycles    = max_cycles_q;
      max_guess     = max_guess_q;
      found         = found_q;
      found_guess   = found_guess_q;
   end

endmodule

// File: tb/tb_reply_latency_meter.sv
// Directed bench for reply_latency_meter: table of reply measurements plus hand sequences
// for timeout, clear, stale reply, abort and mid-measure reset.
module tb_reply_latency_meter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        sw, gs, cs;
   logic [7:0]  gb, bb;

   logic        rv, fd, t_rv, t_fd;
   logic [7:0]  rg, mg, fg, t_rg, t_mg, t_fg;
   logic [23:0] rc, mc, t_rc, t_mc;
   logic [1:0]  rk, t_rk;

   reply_latency_meter #(.CNT_W(24), .TIMEOUT(64)) dut (
      .CLK_50(clk), .SW(sw), .guess_sent(gs), .guess_byte(gb), .bus_byte(bb),
      .clear_stats(cs), .result_valid(rv), .result_guess(rg), .result_cycles(rc),
      .result_kind(rk), .max_cycles(mc), .max_guess(mg), .found(fd), .found_guess(fg)
   );

   reply_latency_meter #(.CNT_W(24), .TIMEOUT(16)) dut_to (
      .CLK_50(clk), .SW(sw), .guess_sent(gs), .guess_byte(gb), .bus_byte(bb),
      .clear_stats(cs), .result_valid(t_rv), .result_guess(t_rg), .result_cycles(t_rc),
      .result_kind(t_rk), .max_cycles(t_mc), .max_guess(t_mg), .found(t_fd),
      .found_guess(t_fg)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0]  guess;
      logic [7:0]  reply;
      int          k;
      logic [1:0]  kind;
      logic [23:0] max_c;
      logic [7:0]  max_g;
      logic        found;
      logic [7:0]  found_g;
   } vec_t;

   vec_t vecs[6];

   function automatic vec_t mk(input logic [7:0] g, input logic [7:0] r, input int k,
                               input logic [1:0] kd, input logic [23:0] mxc,
                               input logic [7:0] mxg, input logic f, input logic [7:0] fgv);
      vec_t v;
      v.guess = g; v.reply = r; v.k = k; v.kind = kd;
      v.max_c = mxc; v.max_g = mxg; v.found = f; v.found_g = fgv;
      return v;
   endfunction

   // Guess at cycle T, reply placed on the bus in cycle T+1+k, result checked at T+2+k,
   // statistics checked at T+3+k.
   task automatic run_meas(input vec_t v, input int idx);
      int    early;
      string p;
      early = 0;
      p = $sformatf("vec%0d", idx);
      @(negedge clk); gb = v.guess; bb = 8'h05; gs = 1'b1;
      @(negedge clk); gs = 1'b0;
      for (int i = 0; i < v.k; i++) begin
         if (rv) early++;
         @(negedge clk);
      end
      if (rv) early++;
      bb = v.reply;
      @(negedge clk);
      bb = 8'h05;
      chk({p, "_no_early_pulse"}, early, 0);
      chk({p, "_valid"}, rv, 1);
      chk({p, "_guess"}, rg, v.guess);
      chk({p, "_cycles"}, rc, v.k);
      chk({p, "_kind"}, rk, v.kind);
      @(negedge clk);
      chk({p, "_valid_drop"}, rv, 0);
      chk({p, "_max_cycles"}, mc, v.max_c);
      chk({p, "_max_guess"}, mg, v.max_g);
      chk({p, "_found"}, fd, v.found);
      chk({p, "_found_guess"}, fg, v.found_g);
   endtask

   initial begin
      int early;
      int hit;
      int seen;
      logic [1:0]  cap_k;
      logic [23:0] cap_c;
      logic [7:0]  cap_g;

      vecs[0] = mk(8'h06, 8'h04,  9, 2'b00,  9, 8'h06, 1'b0, 8'h00);
      vecs[1] = mk(8'h07, 8'h04, 12, 2'b00, 12, 8'h07, 1'b0, 8'h00);
      vecs[2] = mk(8'h08, 8'h04, 12, 2'b00, 12, 8'h07, 1'b0, 8'h00);
      vecs[3] = mk(8'h09, 8'h04,  5, 2'b00, 12, 8'h07, 1'b0, 8'h00);
      vecs[4] = mk(8'h2A, 8'h03,  3, 2'b01, 12, 8'h07, 1'b1, 8'h2A);
      vecs[5] = mk(8'h2B, 8'h03, 20, 2'b01, 20, 8'h2B, 1'b1, 8'h2A);

      sw = 1'b1; gs = 1'b0; cs = 1'b0; gb = 8'h00; bb = 8'h00;
      repeat (2) @(negedge clk);
      sw = 1'b0;
      chk("rst_valid", rv, 0);
      chk("rst_guess", rg, 0);
      chk("rst_cycles", rc, 0);
      chk("rst_kind", rk, 0);
      chk("rst_max_cycles", mc, 0);
      chk("rst_max_guess", mg, 0);
      chk("rst_found", fd, 0);
      chk("rst_found_guess", fg, 0);
      bb = 8'h05;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_meas(vecs[i], i);

      // Short-timeout instance: k=20 in vec5 timed out there, stats untouched.
      chk("to_pre_max_cycles", t_mc, 12);
      chk("to_pre_max_guess", t_mg, 8'h07);
      chk("to_pre_found_guess", t_fg, 8'h2A);

      // Timeout with no reply
      @(negedge clk); gb = 8'h33; bb = 8'h05; gs = 1'b1;
      hit = 0; seen = 0; cap_k = '0; cap_c = '0; cap_g = '0;
      for (int n = 1; n <= 70; n++) begin
         @(negedge clk); gs = 1'b0;
         if (t_rv) begin
            if (hit == 0) hit = n;
            seen++;
            cap_k = t_rk; cap_c = t_rc; cap_g = t_rg;
         end
      end
      chk("to_latency", hit, 17);
      chk("to_pulse_count", seen, 1);
      chk("to_kind", cap_k, 2'b10);
      chk("to_cycles", cap_c, 16);
      chk("to_guess", cap_g, 8'h33);
      chk("to_max_cycles", t_mc, 12);
      chk("to_max_guess", t_mg, 8'h07);
      chk("to_found", t_fd, 1);
      chk("to_found_guess", t_fg, 8'h2A);
      chk("to64_kind", rk, 2'b10);
      chk("to64_cycles", rc, 64);
      chk("to64_max_cycles", mc, 20);

      // clear_stats leaves result_* alone
      @(negedge clk); cs = 1'b1;
      @(negedge clk); cs = 1'b0;
      chk("clr_max_cycles", mc, 0);
      chk("clr_max_guess", mg, 0);
      chk("clr_found", fd, 0);
      chk("clr_found_guess", fg, 0);
      chk("clr_result_cycles", rc, 64);
      chk("clr_result_kind", rk, 2'b10);
      chk("clr_result_guess", rg, 8'h33);

      // Stale reply already on the bus at guess time
      @(negedge clk); gb = 8'h44; bb = 8'h04; gs = 1'b1;
      early = 0;
      for (int k = 0; k <= 30; k++) begin
         @(negedge clk); gs = 1'b0;
         if (rv) early++;
         bb = (k < 20) ? 8'h04 : ((k < 30) ? 8'h00 : 8'h04);
      end
      @(negedge clk); bb = 8'h05;
      chk("stale_no_early_pulse", early, 0);
      chk("stale_valid", rv, 1);
      chk("stale_cycles", rc, 30);
      chk("stale_kind", rk, 2'b00);
      chk("stale_guess", rg, 8'h44);
      @(negedge clk);
      chk("stale_max_cycles", mc, 30);

      // Abort: second guess at k=4 restarts counting from 0
      @(negedge clk); gb = 8'h55; bb = 8'h05; gs = 1'b1;
      @(negedge clk); gs = 1'b0;
      early = 0;
      for (int i = 0; i < 4; i++) begin
         if (rv) early++;
         @(negedge clk);
      end
      gb = 8'h56; gs = 1'b1;
      @(negedge clk); gs = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (rv) early++;
         @(negedge clk);
      end
      if (rv) early++;
      bb = 8'h04;
      @(negedge clk); bb = 8'h05;
      chk("abort_no_early_pulse", early, 0);
      chk("abort_valid", rv, 1);
      chk("abort_guess", rg, 8'h56);
      chk("abort_cycles", rc, 6);
      @(negedge clk);
      chk("abort_single_pulse", rv, 0);

      // Reset mid-measure
      @(negedge clk); gb = 8'h60; gs = 1'b1;
      @(negedge clk); gs = 1'b0;
      repeat (3) @(negedge clk);
      sw = 1'b1;
      @(negedge clk); sw = 1'b0;
      chk("mrst_valid", rv, 0);
      chk("mrst_guess", rg, 0);
      chk("mrst_cycles", rc, 0);
      chk("mrst_kind", rk, 0);
      chk("mrst_max_cycles", mc, 0);
      chk("mrst_max_guess", mg, 0);
      chk("mrst_found", fd, 0);
      chk("mrst_found_guess", fg, 0);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         bb = (i < 10) ? 8'h04 : 8'h05;
         @(negedge clk);
         if (rv) seen++;
      end
      chk("mrst_no_pulse", seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
